// File: rtl/alu_arith_pkg.sv
// Shared encodings, flag positions, divider timing and helpers for the ALU arithmetic slice.
package alu_arith_pkg;

    localparam int DATA_W     = 32;
    localparam int DIV_CYCLES = 33;

    typedef enum logic [1:0] {
        ADDU = 2'b00,
        SUBU = 2'b01,
        ADD  = 2'b10,
        SUB  = 2'b11
    } sign_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_LT  = 3'b010,
        CMP_LTU = 3'b011,
        CMP_GEZ = 3'b100,
        CMP_GTZ = 3'b101,
        CMP_LEZ = 3'b110,
        CMP_LTZ = 3'b111
    } cmp_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } div_res_t;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/alu_arith_if.sv
// Operand/result bundle between the ALU issue logic and the arithmetic slice.
interface alu_arith_if
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       sign;
    logic [2:0]       cmpsignal;
    logic             div_start;
    logic [WIDTH-1:0] Y;
    logic [3:0]       carryFlag;
    logic [WIDTH-1:0] cmpResult;
    logic [WIDTH-1:0] outHI;
    logic [WIDTH-1:0] outLO;
    logic             div_busy;
    logic             div_done;

    modport master (
        output A, B, sign, cmpsignal, div_start,
        input  Y, carryFlag, cmpResult, outHI, outLO, div_busy, div_done
    );

    modport slave (
        input  A, B, sign, cmpsignal, div_start,
        output Y, carryFlag, cmpResult, outHI, outLO, div_busy, div_done
    );
endinterface

// File: rtl/alu_div_seq.sv
// Purpose: restoring signed/unsigned divider producing quotient (lo) and remainder (hi).
// Latency: capture on the start edge, 32 iteration edges, result + done on the 33rd edge after start.
// Backpressure: start is ignored while busy; a new start is taken on the cycle done is high.
module alu_div_seq
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output div_res_t         res
);
    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam int ITER  = DIV_CYCLES - 1;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             dvz_q, dvz_d;
    logic             done_q, done_d;
    div_res_t         res_q, res_d;
    logic [WIDTH:0]   shifted;
    logic             fits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            dvz_q   <= dvz_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        dvz_d   = dvz_q;
        done_d  = 1'b0;
        res_d   = res_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = abs_val(dividend, is_signed);
                    dvs_d   = abs_val(divisor, is_signed);
                    a_neg_d = is_signed & dividend[WIDTH-1];
                    b_neg_d = is_signed & divisor[WIDTH-1];
                    dvz_d   = (divisor == '0);
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(ITER)) begin
                    // Divide-by-zero leaves |A| in the remainder, so only the quotient needs forcing.
                    res_d.lo = dvz_q ? '1 : ((a_neg_q ^ b_neg_q) ? (~quo_q + WIDTH'(1)) : quo_q);
                    res_d.hi = a_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    rem_d = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: rtl/alu_arith_unit.sv
// Purpose: registered add/sub with V/N/Z/C flags, comparator, and a sequential divider.
// Latency: add/sub and compare 1 cycle; divide 33 cycles from the accepted start.
// Backpressure: add/compare never stall; divider start is dropped while div_busy is high.
module alu_arith_unit
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic       clk,
    input  logic       reset,
    alu_arith_if.slave bus
);
    logic             sub_op;
    logic             signed_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [3:0]       flags_d;
    logic             cmp_hit;
    logic [WIDTH-1:0] y_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] cmp_q;
    div_res_t         div_res;

    always_comb begin
        sub_op    = 1'b0;
        signed_op = 1'b0;
        unique case (sign_e'(bus.sign))
            ADDU: ;
            SUBU: sub_op = 1'b1;
            ADD:  signed_op = 1'b1;
            SUB: begin
                sub_op    = 1'b1;
                signed_op = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtraction as A + ~B + 1, so carry-out of 1 means no borrow.
    always_comb begin
        b_op            = sub_op ? ~bus.B : bus.B;
        sum             = {1'b0, bus.A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};
        flags_d         = '0;
        flags_d[FLAG_C] = sum[WIDTH];
        flags_d[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        flags_d[FLAG_N] = sum[WIDTH-1];
        flags_d[FLAG_V] = signed_op & (bus.A[WIDTH-1] == b_op[WIDTH-1])
                                    & (sum[WIDTH-1] != bus.A[WIDTH-1]);
    end

    always_comb begin
        cmp_hit = 1'b0;
        unique case (cmp_e'(bus.cmpsignal))
            CMP_EQ:  cmp_hit = (bus.A == bus.B);
            CMP_NE:  cmp_hit = (bus.A != bus.B);
            CMP_LT:  cmp_hit = ($signed(bus.A) < $signed(bus.B));
            CMP_LTU: cmp_hit = (bus.A < bus.B);
            CMP_GEZ: cmp_hit = ~bus.A[WIDTH-1];
            CMP_GTZ: cmp_hit = ~bus.A[WIDTH-1] & (bus.A != '0);
            CMP_LEZ: cmp_hit = bus.A[WIDTH-1] | (bus.A == '0);
            CMP_LTZ: cmp_hit = bus.A[WIDTH-1];
            default: cmp_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= '0;
            flags_q <= '0;
            cmp_q   <= '0;
        end else begin
            y_q     <= sum[WIDTH-1:0];
            flags_q <= flags_d;
            cmp_q   <= {{(WIDTH-1){1'b0}}, cmp_hit};
        end
    end

    alu_div_seq #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (bus.div_start),
        .dividend  (bus.A),
        .divisor   (bus.B),
        .is_signed (bus.sign[1]),
        .busy      (bus.div_busy),
        .done      (bus.div_done),
        .res       (div_res)
    );

    assign bus.Y         = y_q;
    assign bus.carryFlag = flags_q;
    assign bus.cmpResult = cmp_q;
    assign bus.outHI     = div_res.hi;
    assign bus.outLO     = div_res.lo;

endmodule

// File: tb/tb_alu_arith_unit.sv
// Scoreboard bench for alu_arith_unit: directed add/compare vectors and divisions with hand-computed results.
module tb_alu_arith_unit;
    import alu_arith_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arith_if bus ();

    alu_arith_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        logic [31:0] c;
    } arith_exp_t;

    arith_exp_t  arith_q[$];
    logic [63:0] div_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of each queue.
    initial begin
        arith_exp_t e;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (arith_q.size() > 0) begin
                e = arith_q.pop_front();
                check("arith_Y", 64'(bus.Y), 64'(e.y));
                check("arith_flags", 64'(bus.carryFlag), 64'(e.f));
                check("arith_cmp", 64'(bus.cmpResult), 64'(e.c));
            end
            if (bus.div_done === 1'b1) begin
                if (div_q.size() == 0) begin
                    check("div_done_spurious", 64'(bus.div_done), 64'd0);
                end else begin
                    d = div_q.pop_front();
                    check("div_hi_lo", {bus.outHI, bus.outLO}, d);
                end
            end
        end
    end

    task automatic apply_arith(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] c, input logic [31:0] y, input logic [3:0] f,
                               input logic cr);
        @(negedge clk);
        #1;
        bus.A         = a;
        bus.B         = b;
        bus.sign      = s;
        bus.cmpsignal = c;
        arith_q.push_back('{y, f, {31'd0, cr}});
    endtask

    task automatic run_div(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input bit extras);
        int lat;
        bit busy_ok;
        @(negedge clk);
        #1;
        bus.A         = a;
        bus.B         = b;
        bus.sign      = s;
        bus.div_start = 1'b1;
        div_q.push_back({ehi, elo});
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (bus.div_done === 1'b1) begin
                lat = k;
                check("div_busy_clear", 64'(bus.div_busy), 64'd0);
                break;
            end
            if (bus.div_busy !== 1'b1) busy_ok = 1'b0;
            #1;
            bus.div_start = 1'b0;
            if (extras && k == 5) begin
                bus.A         = 32'd3;
                bus.B         = 32'd4;
                bus.sign      = ADDU;
                bus.cmpsignal = CMP_EQ;
                arith_q.push_back('{32'd7, 4'b0000, 32'd0});
            end
            if (extras && k == 10) begin
                bus.A         = 32'd50;
                bus.B         = 32'd5;
                bus.sign      = ADDU;
                bus.div_start = 1'b1;
            end
        end
        bus.div_start = 1'b0;
        check("div_latency", 64'(lat), 64'(DIV_CYCLES));
        check("div_busy_held", 64'(busy_ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.sign      = '0;
        bus.cmpsignal = '0;
        bus.div_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_Y", 64'(bus.Y), 64'd0);
        check("rst_flags", 64'(bus.carryFlag), 64'd0);
        check("rst_cmp", 64'(bus.cmpResult), 64'd0);
        check("rst_hi_lo", {bus.outHI, bus.outLO}, 64'd0);
        check("rst_busy_done", 64'({bus.div_busy, bus.div_done}), 64'd0);
        #1 reset = 1'b0;

        //          sign  A             B             cmp     Y             CZNV     cmp
        apply_arith(ADDU, 32'hFFFFFFFF, 32'h00000001, CMP_LT,  32'h00000000, 4'b1100, 1'b1);
        apply_arith(SUB,  32'h80000000, 32'h00000001, CMP_LTU, 32'h7FFFFFFF, 4'b1001, 1'b0);
        apply_arith(SUBU, 32'hFFFFFFFF, 32'h00000001, CMP_LTZ, 32'hFFFFFFFE, 4'b1010, 1'b1);
        apply_arith(SUBU, 32'h00000001, 32'h00000002, CMP_LTU, 32'hFFFFFFFF, 4'b0010, 1'b1);
        apply_arith(ADD,  32'h7FFFFFFF, 32'h00000001, CMP_EQ,  32'h80000000, 4'b0011, 1'b0);
        apply_arith(SUB,  32'h00000005, 32'h00000005, CMP_EQ,  32'h00000000, 4'b1100, 1'b1);
        apply_arith(ADDU, 32'h7FFFFFFF, 32'h00000001, CMP_NE,  32'h80000000, 4'b0010, 1'b1);
        apply_arith(ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, CMP_GEZ, 32'hFFFFFFFE, 4'b1010, 1'b0);
        apply_arith(ADD,  32'h00000000, 32'h00000000, CMP_GTZ, 32'h00000000, 4'b0100, 1'b0);
        apply_arith(SUBU, 32'h00000000, 32'h00000000, CMP_LEZ, 32'h00000000, 4'b1100, 1'b1);
        apply_arith(ADDU, 32'h00000001, 32'h00000000, CMP_GTZ, 32'h00000001, 4'b0000, 1'b1);
        apply_arith(SUB,  32'h80000000, 32'h7FFFFFFF, CMP_LT,  32'h00000001, 4'b1001, 1'b1);
        apply_arith(ADD,  32'h80000000, 32'h80000000, CMP_LEZ, 32'h00000000, 4'b1101, 1'b1);
        apply_arith(ADDU, 32'h00000000, 32'h00000005, CMP_GEZ, 32'h00000005, 4'b0000, 1'b1);
        apply_arith(ADDU, 32'hFFFFFFFF, 32'h00000001, CMP_LTU, 32'h00000000, 4'b1100, 1'b0);
        @(negedge clk);

        //      sign  A             B             HI            LO            mid-run extras
        run_div(ADD,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        run_div(ADDU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0);
        run_div(ADDU, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_div(ADD,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_div(ADD,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_div(ADD,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0);
        run_div(ADDU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0);
        run_div(SUB,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);

        // Abort a division in flight with reset sampled at the tenth edge after start.
        @(negedge clk);
        #1;
        bus.A         = 32'd1000;
        bus.B         = 32'd3;
        bus.sign      = ADDU;
        bus.cmpsignal = CMP_NE;
        bus.div_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            bus.div_start = 1'b0;
            if (k == 9) reset = 1'b1;
        end
        @(negedge clk);
        check("abort_Y", 64'(bus.Y), 64'd0);
        check("abort_flags", 64'(bus.carryFlag), 64'd0);
        check("abort_cmp", 64'(bus.cmpResult), 64'd0);
        check("abort_hi_lo", {bus.outHI, bus.outLO}, 64'd0);
        check("abort_busy_done", 64'({bus.div_busy, bus.div_done}), 64'd0);
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", 64'(bus.div_busy), 64'd0);
        check("abort_hi_lo_hold", {bus.outHI, bus.outLO}, 64'd0);

        repeat (2) @(negedge clk);
        check("div_queue_drained", 64'(div_q.size()), 64'd0);
        check("arith_queue_drained", 64'(arith_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arith_unit.md
Name: alu_arith_unit

Overview:
Registered arithmetic slice of the ALU datapath. It bundles three functions:
- 32-bit add/subtract with V/N/Z/C flags.
- 3-bit-coded comparator producing a 32-bit 0/1 result.
- Multi-cycle signed/unsigned divider producing HI (remainder) and LO (quotient).

Add/compare results are registered every cycle. The divider uses a start/busy/done handshake.

Parameters:
WIDTH, 32, data width (all arithmetic rules below assume 32).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
A  in  32  operand A (dividend for division).
B  in  32  operand B (divisor for division).
sign  in  2  00 add unsigned, 01 sub unsigned, 10 add signed, 11 sub signed; divider uses sign[1] only (1 = signed).
cmpsignal  in  3  comparator select.
div_start  in  1  start-division request.
Y  out  32  registered add/sub result.
carryFlag  out  4  registered flags: [0]=V, [1]=N, [2]=Z, [3]=C.
cmpResult  out  32  registered compare result, 32'd1 or 32'd0.
outHI  out  32  division remainder.
outLO  out  32  division quotient.
div_busy  out  1  divider running.
div_done  out  1  one-cycle pulse when outHI/outLO are updated.

Behaviour:
- Reset: on a clk edge with reset=1, all outputs go to 0 and any division in flight is aborted (no done pulse). Reset has priority over everything.
- Add/sub, 1-cycle latency; Y and flags register A,B,sign every edge.
  - Add: A+B. Sub: A+~B+1.
  - C = carry out of bit 31; for subtraction C=1 means no borrow.
  - Z = (result==0). N = result[31].
  - V = two's-complement overflow when sign[1]=1; V=0 when sign[1]=0.
- Comparator, 1-cycle latency; cmpResult = 1 if the condition holds, else 0.
  - 000 A==B; 001 A!=B; 010 A<B signed; 011 A<B unsigned.
  - 100 A>=0; 101 A>0; 110 A<=0; 111 A<0 (signed, B ignored).
- Divider handshake:
  - div_start is sampled only when div_busy=0. On that edge (edge 0), capture A, B, sign[1] and set div_busy=1.
  - div_start while busy is ignored.
  - Edges 1..32: one restoring-division iteration per edge on absolute values.
  - Edge 33: apply sign fix-up, write outHI/outLO, pulse div_done=1 for exactly that cycle, clear div_busy.
  - A new div_start may be accepted on the cycle div_done is high (i.e. sampled at edge 34).
  - outHI/outLO hold their values until the next completion or reset.
- Division arithmetic:
  - Unsigned: LO=A/B, HI=A%B.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^31 / -1: LO=0x80000000, HI=0.
  - B==0 (either mode): LO=0xFFFFFFFF, HI=A. Same 33-cycle latency, no exception.
- Simultaneous events: add/compare keep updating every cycle while the divider is busy. Division inputs are the captured copies, so A/B may change freely after edge 0.

Decomposition:
- Package alu_arith_pkg holds:
  - sign encodings: ADDU=2'b00, SUBU=2'b01, ADD=2'b10, SUB=2'b11.
  - cmpsignal codes: CMP_EQ … CMP_LTZ.
  - flag bit indices: FLAG_V=0, FLAG_N=1, FLAG_Z=2, FLAG_C=3.
  - DIV_CYCLES=33.
- One sub-module, alu_div_seq: the sequential divider core with its counter, handshake and fix-up.
- Adder and comparator are combinational logic inside the top level.

Test Plan:
- sign=00, A=0xFFFFFFFF, B=1 → next cycle Y=0, carryFlag=4'b1100 (C=1, Z=1).
- sign=11, A=0x80000000, B=1 → Y=0x7FFFFFFF, carryFlag=4'b1001 (C=1, V=1).
- A=0xFFFFFFFF, B=1:
  - cmpsignal=010 → cmpResult=1.
  - cmpsignal=011 → cmpResult=0.
  - cmpsignal=111 → cmpResult=1.
- div_start with sign=10, A=-7, B=2 → after 33 edges, div_done pulses once with LO=0xFFFFFFFD, HI=0xFFFFFFFF; busy asserted throughout; a second div_start mid-run is ignored.
- sign=00, A=0x1234, B=0, div_start → after 33 edges LO=0xFFFFFFFF, HI=0x1234; then A=100, B=7 → LO=14, HI=2.
- Start a division, assert reset at edge 10 → all outputs 0, div_busy=0, no div_done pulse afterward.
